// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite master driven by a cmd/rsp handshake.
// Latency: command accept to rsp_valid is 3 edges (4 cycles) with a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready. AXI_MASTER_TIMEOUT_EN adds a wait timeout.
module axi_lite_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [3:0]            WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  // A timeout value of zero would make the wait counter meaningless.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_degenerate
  end

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]           wait_cnt_q, wait_cnt_d;
  logic                  waiting;
`endif

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;

    case (state_q)
      IDLE: begin
        // cmd_ready_q is still 0 in the cycle right after reset, so no accept there.
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      WR: begin
        // AW and W retire independently; a channel whose valid is already low is done.
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (bready_q && BVALID) begin
          bready_d    = 1'b0;
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end

      RD_ADDR: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (rready_q && RVALID) begin
          rready_d    = 1'b0;
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // Debug escape hatch: abandon a stalled handshake and report resp 11.
    // Forward progress in the same cycle wins over the timeout.
    waiting    = (state_q == WR) || (state_q == WR_RESP) ||
                 (state_q == RD_ADDR) || (state_q == RD_DATA);
    wait_cnt_d = '0;
    if (waiting && (state_d == state_q)) begin
      wait_cnt_d = 16'(wait_cnt_q + 16'd1);
      if (wait_cnt_q == TMO_LAST) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_resp_d  = 2'b11;
        rsp_rdata_d = '0;
        state_d     = RESP;
        wait_cnt_d  = '0;
      end
    end
`endif
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  // Handshake wait counter.
  always_ff @(posedge ACLK) begin
    if (ARESET) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign AWADDR    = awaddr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = araddr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: write, read, AW backpressure, rsp backpressure, reset abort.
// Inputs driven and outputs sampled on the falling edge; DUT registers on the rising edge.
// Handshake counters watch every AXI channel so duplicate or missing beats are caught.
module tb_axi_lite_cmd_master;

  logic        ACLK;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  int n_chk  = 0;
  int n_pass = 0;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;

  axi_lite_cmd_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Handshake monitor.
  always @(posedge ACLK) begin
    if (!ARESET) begin
      if (AWVALID && AWREADY) aw_n++;
      if (WVALID && WREADY)   w_n++;
      if (BVALID && BREADY)   b_n++;
      if (ARVALID && ARREADY) ar_n++;
      if (RVALID && RREADY)   r_n++;
    end
  end

  task automatic cyc();
    @(negedge ACLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  initial begin
    ARESET = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;

    // ---- reset state
    cyc(); cyc();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {AWVALID, WVALID, ARVALID, rsp_valid}, 0);
    chk("rst_readys", {BREADY, RREADY}, 0);
    chk("rst_payload", {rsp_rdata, rsp_resp, AWADDR[29:0]}, 0);
    chk("rst_payload2", {ARADDR, WDATA}, 0);
    chk("rst_wstrb", WSTRB, 0);
    ARESET = 1'b0;
    cyc();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // ---- write, B two cycles after W handshake
    AWREADY = 1; WREADY = 1;
    send(1'b1, 32'h0, 32'h0000_00A5, 4'b0011);
    cyc();
    cmd_valid = 0;
    chk("wr_awvalid", AWVALID, 1);
    chk("wr_wvalid", WVALID, 1);
    chk("wr_awaddr", AWADDR, 32'h0);
    chk("wr_wdata", WDATA, 32'hA5);
    chk("wr_wstrb", WSTRB, 4'b0011);
    chk("wr_cmd_ready_busy", cmd_ready, 0);
    cyc();
    chk("wr_valids_drop", {AWVALID, WVALID}, 2'b00);
    chk("wr_bready", BREADY, 1);
    cyc();
    chk("wr_bready_wait", BREADY, 1);
    chk("wr_no_rsp_yet", rsp_valid, 0);
    BVALID = 1; BRESP = 2'b00;
    cyc();
    BVALID = 0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_resp", rsp_resp, 2'b00);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_bready_drop", BREADY, 0);
    chk("wr_hs_counts", {aw_n[7:0], w_n[7:0], b_n[7:0]}, {8'd1, 8'd1, 8'd1});
    rsp_ready = 1;
    cyc();
    rsp_ready = 0;
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_back_idle", cmd_ready, 1);

    // ---- stray BVALID in IDLE is ignored
    BVALID = 1; BRESP = 2'b10;
    cyc();
    chk("idle_bready_low", BREADY, 0);
    chk("idle_no_b_hs", b_n, 1);
    BVALID = 0;

    // ---- zero-wait read
    ARREADY = 1; RVALID = 1; RDATA = 32'hDEADBEEF; RRESP = 2'b00;
    send(1'b0, 32'h4, 32'h0, 4'h0);
    cyc();
    cmd_valid = 0;
    chk("rd_arvalid", ARVALID, 1);
    chk("rd_araddr", ARADDR, 32'h4);
    chk("rd_rready_early", RREADY, 0);
    cyc();
    chk("rd_rready", {ARVALID, RREADY, rsp_valid}, 3'b010);
    cyc();
    chk("rd_rsp_valid_lat", rsp_valid, 1);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_resp", rsp_resp, 2'b00);
    chk("rd_hs_counts", {ar_n[7:0], r_n[7:0]}, {8'd1, 8'd1});
    RVALID = 0;
    rsp_ready = 1;
    cyc();
    rsp_ready = 0;

    // ---- write with AWREADY held low 5 cycles, EXOKAY response
    AWREADY = 0; WREADY = 1; BVALID = 1; BRESP = 2'b01;
    send(1'b1, 32'h10, 32'h1234_5678, 4'hF);
    cyc();
    cmd_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      chk("bp_awvalid_held", AWVALID, 1);
      chk("bp_awaddr_stable", AWADDR, 32'h10);
      chk("bp_wvalid", WVALID, (i == 1) ? 1'b1 : 1'b0);
      cyc();
    end
    chk("bp_awvalid_6th", AWVALID, 1);
    AWREADY = 1;
    cyc();
    chk("bp_aw_drop", {AWVALID, BREADY}, 2'b01);
    cyc();
    BVALID = 0;
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_exokay", rsp_resp, 2'b01);
    chk("bp_hs_counts", {aw_n[7:0], w_n[7:0], b_n[7:0]}, {8'd2, 8'd2, 8'd2});
    rsp_ready = 1;
    cyc();
    rsp_ready = 0;

    // ---- read with SLVERR and rsp_ready held low 4 cycles
    ARREADY = 1; RVALID = 1; RDATA = 32'hCAFE_0001; RRESP = 2'b10;
    send(1'b0, 32'h8, 32'h0, 4'h0);
    cyc();
    AWREADY = 0; WREADY = 0;
    send(1'b1, 32'h20, 32'h55, 4'h1);
    cyc(); cyc();
    RVALID = 0;
    for (int i = 0; i < 4; i++) begin
      chk("rbp_rsp_valid", rsp_valid, 1);
      chk("rbp_rdata", rsp_rdata, 32'hCAFE_0001);
      chk("rbp_resp", rsp_resp, 2'b10);
      chk("rbp_cmd_ready", cmd_ready, 0);
      chk("rbp_no_accept", AWVALID, 0);
      cyc();
    end
    rsp_ready = 1;
    cyc();
    rsp_ready = 0;
    chk("rbp_rsp_done", rsp_valid, 0);
    chk("rbp_cmd_ready_back", cmd_ready, 1);
    chk("rbp_not_yet_accepted", AWVALID, 0);
    cyc();
    cmd_valid = 0;
    chk("rbp_accept_late", {AWVALID, WVALID, cmd_ready}, 3'b110);
    chk("rbp_awaddr", AWADDR, 32'h20);

    // ---- reset while AWVALID=1 and AWREADY=0
    ARESET = 1;
    cyc();
    chk("abort_valids", {AWVALID, WVALID}, 2'b00);
    chk("abort_no_rsp", rsp_valid, 0);
    chk("abort_rdata_clr", rsp_rdata, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    ARESET = 0;
    cyc();
    chk("abort_idle", {cmd_ready, rsp_valid}, 2'b10);

    // ---- write after abort completes normally
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b00;
    send(1'b1, 32'h24, 32'h0000_0F0F, 4'b0100);
    cyc();
    cmd_valid = 0;
    chk("re_awaddr", AWADDR, 32'h24);
    chk("re_wdata", WDATA, 32'h0F0F);
    chk("re_wstrb", WSTRB, 4'b0100);
    cyc();
    chk("re_bready", BREADY, 1);
    cyc();
    BVALID = 0;
    chk("re_rsp", {rsp_valid, rsp_resp}, 3'b100);
    chk("re_rdata", rsp_rdata, 0);
    chk("re_b_count", b_n, 3);
    rsp_ready = 1;
    cyc();
    rsp_ready = 0;

`ifdef AXI_MASTER_TIMEOUT_EN
    // ---- timeout on a stuck ARREADY
    begin
      int n;
      ARREADY = 0;
      send(1'b0, 32'hC, 32'h0, 4'h0);
      cyc();
      cmd_valid = 0;
      n = 0;
      while (ARVALID && n < 400) begin
        n++;
        cyc();
      end
      chk("tmo_arvalid_cycles", n, 256);
      chk("tmo_rsp_valid", rsp_valid, 1);
      chk("tmo_resp", rsp_resp, 2'b11);
      chk("tmo_rdata", rsp_rdata, 0);
      rsp_ready = 1;
      cyc();
      rsp_ready = 0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
AXI4-Lite master that turns a simple single-beat command/response interface into AXI4-Lite write and read transactions. It sits directly upstream of the LED/register AXI4-Lite slave and drives all five of its channels. Only one transaction is outstanding at a time. Software-side logic, such as a UART command decoder or test sequencer, issues commands to it.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr / AWADDR / ARADDR
DATA_WIDTH, 32, width of data buses; fixed at 32 (WSTRB is 4 bits)
TIMEOUT_CYCLES, 256, handshake wait limit; used only with AXI_MASTER_TIMEOUT_EN

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  4  byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  00 OKAY, 10 SLVERR, 11 timeout
AWADDR  out  ADDR_WIDTH
AWVALID  out  1
AWREADY  in  1
WDATA  out  DATA_WIDTH
WSTRB  out  4
WVALID  out  1
WREADY  in  1
BRESP  in  2
BVALID  in  1
BREADY  out  1
ARADDR  out  ADDR_WIDTH
ARVALID  out  1
ARREADY  in  1
RDATA  in  DATA_WIDTH
RRESP  in  2
RVALID  in  1
RREADY  out  1

Behaviour:
- Reset (ARESET=1 at an edge) sets the following:
  - state IDLE.
  - All VALID/READY outputs 0.
  - cmd_ready 0 in the reset cycle, then 1.
  - rsp_valid 0; rsp_rdata, rsp_resp, AWADDR, ARADDR, WDATA, WSTRB all 0.
- Reset asserted mid-transaction aborts it at that edge: all valids drop and no response is produced.
- All outputs are registered.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at edge N, latch addr/data/strb.
  - If cmd_write, go to WR with AWVALID=WVALID=1 from N+1.
  - If read, go to RD_ADDR with ARVALID=1 from N+1.
- WR:
  - AW and W are independent. Each VALID is held with its payload stable until its own handshake (VALID && READY at an edge), then cleared next cycle.
  - Handshakes may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP with BREADY=1.
- WR_RESP:
  - On BVALID && BREADY, capture BRESP into rsp_resp; rsp_rdata=0; BREADY drops; go to RESP.
  - BRESP 01 (EXOKAY) is passed through unchanged.
- RD_ADDR:
  - Hold ARVALID and ARADDR until ARREADY.
  - Then go to RD_DATA with RREADY=1.
- RD_DATA:
  - On RVALID, capture RDATA/RRESP; RREADY drops; go to RESP.
- RESP:
  - rsp_valid=1, held with payload stable until rsp_ready.
  - Then go to IDLE.
  - cmd_ready=0 in every state except IDLE.
- Minimum latency is 4 cycles from command accept to rsp_valid, with a zero-wait slave:
  - write: accept N, AW/W handshake N+1, B handshake N+2, rsp_valid N+3.
  - read: accept N, AR handshake N+1, R handshake N+2, rsp_valid N+3.
- No new command while in RESP; back-to-back commands are separated by at least one IDLE cycle.
- Unexpected BVALID/RVALID outside WR_RESP/RD_DATA is ignored (READY stays 0).

Optional Feature:
AXI_MASTER_TIMEOUT_EN:
- Defined:
  - A 16-bit wait counter clears on every state change and counts in WR, WR_RESP, RD_ADDR, RD_DATA.
  - When it reaches TIMEOUT_CYCLES, all AXI valids/readys drop next edge and the FSM goes to RESP with rsp_resp=11 and rsp_rdata=0.
  - This is a debug aid and deliberately violates AXI VALID persistence.
- Undefined:
  - No counter; the master waits indefinitely.

Test Plan:
- Write: addr 0x0, wdata 0x0000_00A5, wstrb 0011, slave BVALID 2 cycles after W handshake with BRESP 00 → exactly one AW, W and B handshake; AWADDR 0x0, WDATA 0xA5, WSTRB 0011; rsp_resp 00, rsp_rdata 0.
- Read: addr 0x4, slave RDATA 0xDEADBEEF, RRESP 00, zero wait → rsp_valid exactly 4 cycles after accept; rsp_rdata 0xDEADBEEF.
- Write backpressure: WREADY=1 immediately, AWREADY held 0 for 5 cycles → WVALID low after 1 cycle; AWVALID held 6 cycles with AWADDR stable; single B handshake after.
- Response backpressure: rsp_ready 0 for 4 cycles after rsp_valid → rsp_valid/rsp_rdata stable, cmd_ready 0, a new cmd_valid not accepted until 1 cycle after rsp_ready.
- Reset mid-write: ARESET pulsed while AWVALID=1 and AWREADY=0 → AWVALID/WVALID 0 at next edge, no rsp_valid, next write completes normally.
- AXI_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=256: read with ARREADY stuck 0 → ARVALID drops after 256 cycles; rsp_resp 11, rsp_rdata 0.
